// File: rtl/bcd_display_pkg.sv
// Shared types and segment constants for the BCD display scheduler.
package bcd_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    typedef logic [3:0] digit_t;

    // Segment order is {g,f,e,d,c,b,a}, active-low, for a common-anode display
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/bin6_to_bcd.sv
// Combinational 6-bit binary to two-digit BCD converter (shift-and-add-3).
module bin6_to_bcd
    import bcd_display_pkg::*;
(
    input  logic [5:0] bin,
    output digit_t     tens,
    output digit_t     ones
);

    logic [7:0] bcd;
    logic [5:0] sh;

    always_comb begin
        bcd = '0;
        sh  = bin;
        for (int i = 0; i < 6; i++) begin
            // Correct any digit that would exceed 9 once doubled by the next shift
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[6:0], sh[5]};
            sh  = {sh[4:0], 1'b0};
        end
    end

    assign tens = bcd[7:4];
    assign ones = bcd[3:0];

endmodule

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes
// and an asserted blank flag both produce a dark digit.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  digit_t     digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Round-robin scheduler sharing one 6-bit BCD converter among NUM_SRC sources and
// scanning the results onto a 2*NUM_SRC digit display. Option: LEADING_ZERO_BLANK_EN.
module bcd_display_scheduler
    import bcd_display_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [6*NUM_SRC-1:0]   val,
    output logic [NUM_SRC-1:0]     ack,
    output logic                   busy,
    output logic [2*NUM_SRC-1:0]   an,
    output logic [6:0]             seg
);

    localparam int NUM_DIG = 2 * NUM_SRC;
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int IDX_W   = $clog2(NUM_DIG);
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t             state;
    logic [5:0]         conv_in;
    logic [SRC_W-1:0]   src_id;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   next_ptr;
    logic               grant_found;
    logic [5:0]         src_val [NUM_SRC];
    digit_t             slot [NUM_DIG];
    digit_t             conv_tens;
    digit_t             conv_ones;
    logic [IDX_W-1:0]   wr_hi;
    logic [IDX_W-1:0]   wr_lo;
    logic [DIV_W-1:0]   div;
    logic [IDX_W-1:0]   idx;
    digit_t             shown;
    logic               blank;
    logic [6:0]         seg_next;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src_val
        assign src_val[k] = val[6*k +: 6];
    end

    // Search starts at rr_ptr and wraps, so the source served last has lowest priority
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        winner      = rr_ptr;
        grant_found = 1'b0;
        cand        = rr_ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_found && req[cand]) begin
                winner      = cand;
                grant_found = 1'b1;
            end
            cand = (cand == SRC_W'(NUM_SRC - 1)) ? '0 : cand + 1'b1;
        end
    end

    assign next_ptr = (src_id == SRC_W'(NUM_SRC - 1)) ? '0 : src_id + 1'b1;
    assign wr_lo    = IDX_W'({src_id, 1'b0});
    assign wr_hi    = IDX_W'({src_id, 1'b1});

    bin6_to_bcd u_conv (
        .bin  (conv_in),
        .tens (conv_tens),
        .ones (conv_ones)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register in
        // this block samples the values from before the edge.
        if (reset) begin
            state   <= IDLE;
            conv_in <= '0;
            src_id  <= '0;
            rr_ptr  <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            // NOTE: the digit file is reset explicitly because the display must read
            // "00" after reset; it is small enough to live in flops, not a RAM macro.
            for (int d = 0; d < NUM_DIG; d++) slot[d] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        conv_in <= src_val[winner];
                        src_id  <= winner;
                        ack     <= NUM_SRC'(1) << winner;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    slot[wr_hi] <= conv_tens;
                    slot[wr_lo] <= conv_ones;
                    rr_ptr      <= next_ptr;
                    ack         <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign shown = slot[idx];

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = idx[0] && (shown == 4'd0);
`else
    assign blank = 1'b0;
`endif

    seg7_decode u_dec (
        .digit (shown),
        .blank (blank),
        .seg   (seg_next)
    );

    // Scanner runs independently of arbitration; an/seg follow idx by one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            if (div == DIV_W'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            an  <= ~(NUM_DIG'(1) << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench for bcd_display_scheduler: a driver predicts grants and digit
// contents, a monitor checks ack and every scanned digit cycle by cycle.
module tb_bcd_display_scheduler;

    localparam int NUM_SRC  = 4;
    localparam int SCAN_DIV = 4;
    localparam int NUM_DIG  = 2 * NUM_SRC;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_SRC-1:0]   req = '0;
    logic [6*NUM_SRC-1:0] val = '0;
    logic [NUM_SRC-1:0]   ack;
    logic                 busy;
    logic [NUM_DIG-1:0]   an;
    logic [6:0]           seg;

    bcd_display_scheduler #(
        .NUM_SRC  (NUM_SRC),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .val   (val),
        .ack   (ack),
        .busy  (busy),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src;
        int value;
    } exp_t;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_rr = 0;
    int   tb_vals[NUM_SRC];
    bit   hold_phase = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int pos, input int digit);
        if (digit < 0 || digit > 9) return 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        if ((pos % 2) == 1 && digit == 0) return 7'h7F;
`endif
        return SEG_TAB[digit];
    endfunction

    // Round-robin reference: first pending source at or after the pointer
    function automatic int pick(input logic [NUM_SRC-1:0] pending);
        for (int i = 0; i < NUM_SRC; i++) begin
            int s = (model_rr + i) % NUM_SRC;
            if (pending[s]) begin
                model_rr = (s + 1) % NUM_SRC;
                return s;
            end
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int s);
        exp_t e;
        e.src   = s;
        e.value = tb_vals[s];
        exp_q.push_back(e);
    endtask

    task automatic run_batch(input logic [NUM_SRC-1:0] mask);
        logic [NUM_SRC-1:0] pend;
        int cyc;
        pend = mask;
        for (int k = 0; k < NUM_SRC; k++)
            if (mask[k]) val[6*k +: 6] = 6'(tb_vals[k]);
        while (pend != 0) begin
            int s;
            s = pick(pend);
            push_exp(s);
            pend[s] = 1'b0;
        end
        req = mask;
        cyc = 0;
        while (req != 0 && cyc < 100) begin
            tick();
            req = req & ~ack;
            cyc++;
        end
        check("batch_done", 32'(req), 32'd0);
        req = '0;
    endtask

    initial begin : monitor
        int   m_slot[NUM_DIG];
        int   k;
        int   didx;
        bit   pend;
        int   p_src;
        int   p_val;
        int   last_k;
        int   hold_seen;
        logic [NUM_DIG-1:0] ean;
        exp_t e;
        k = 0; pend = 0; p_src = 0; p_val = 0; last_k = 0; hold_seen = 0;
        foreach (m_slot[i]) m_slot[i] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_an", 32'(an), 32'hFF);
                check("rst_seg", 32'(seg), 32'h7F);
                check("rst_ack", 32'(ack), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                k = 0;
                pend = 0;
                hold_seen = 0;
                foreach (m_slot[i]) m_slot[i] = 0;
            end else begin
                k++;
                didx = ((k - 1) / SCAN_DIV) % NUM_DIG;
                ean  = ~(NUM_DIG'(1) << didx);
                check("scan_an", 32'(an), 32'(ean));
                check("scan_seg", 32'(seg), 32'(exp_seg(didx, m_slot[didx])));
                if (pend) begin
                    m_slot[2*p_src+1] = p_val / 10;
                    m_slot[2*p_src]   = p_val % 10;
                    pend = 0;
                end
                check("busy", 32'(busy), 32'(ack != 0));
                if (!hold_phase) hold_seen = 0;
                if (ack != 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_grant", 32'(ack), 32'd1 << e.src);
                        pend  = 1;
                        p_src = e.src;
                        p_val = e.value;
                        if (hold_phase) begin
                            if (hold_seen > 0) check("hold_gap", 32'(k - last_k), 32'd2);
                            hold_seen++;
                            last_k = k;
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int cnt;
        int cyc;
        int s;
        foreach (tb_vals[i]) tb_vals[i] = 0;
        repeat (3) tick();
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_lit_an", 32'(an), 32'hFE);
        repeat (70) tick();

        // Single request, one-cycle latency, value 47
        tb_vals[2] = 47;
        val[12 +: 6] = 6'd47;
        s = pick(4'b0100);
        push_exp(s);
        req = 4'b0100;
        tick();
        check("t2_ack_latency", 32'(ack), 32'h4);
        req = '0;
        repeat (40) tick();

        // All sources held: strict rotation, one grant every two cycles
        hold_phase = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            tb_vals[k] = int'($urandom_range(0, 63));
            val[6*k +: 6] = 6'(tb_vals[k]);
        end
        for (int n = 0; n < 8; n++) push_exp(pick(4'b1111));
        req = 4'b1111;
        cnt = 0;
        cyc = 0;
        while (cnt < 8 && cyc < 100) begin
            tick();
            if (ack != 0) cnt++;
            cyc++;
        end
        req = '0;
        check("hold_count", 32'(cnt), 32'd8);
        repeat (2) tick();
        hold_phase = 1'b0;
        repeat (40) tick();

        // Boundary values on source 0
        tb_vals[0] = 63;
        run_batch(4'b0001);
        repeat (40) tick();
        tb_vals[0] = 0;
        run_batch(4'b0001);
        repeat (40) tick();

        // Reset during the ack cycle aborts the write
        repeat (2) tick();
        val[6 +: 6] = 6'd25;
        req = 4'b0010;
        tick();
        check("t5_ack", 32'(ack), 32'h2);
        reset = 1'b1;
        req = '0;
        #1;
        check("t5_ack_drop", 32'(ack), 32'd0);
        check("t5_busy_drop", 32'(busy), 32'd0);
        model_rr = 0;
        repeat (3) tick();
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (70) tick();
        tb_vals[1] = 25;
        s = pick(4'b0010);
        push_exp(s);
        req = 4'b0010;
        tick();
        check("t5_idle_after", 32'(ack), 32'h2);
        req = '0;
        repeat (5) tick();

        // A request raised and dropped while CONV is never latched
        tb_vals[0] = 38;
        val[0 +: 6] = 6'd38;
        s = pick(4'b0001);
        push_exp(s);
        req = 4'b0001;
        tick();
        check("t6_ack0", 32'(ack), 32'h1);
        req = 4'b1000;
        tick();
        req = '0;
        repeat (6) tick();
        tb_vals[0] = 5;
        tb_vals[3] = 10;
        run_batch(4'b1001);
        repeat (40) tick();

        // Randomized batches
        for (int b = 0; b < 40; b++) begin
            logic [NUM_SRC-1:0] mask;
            mask = NUM_SRC'($urandom_range(1, 15));
            for (int k = 0; k < NUM_SRC; k++) begin
                case ($urandom_range(0, 5))
                    0:       tb_vals[k] = 0;
                    1:       tb_vals[k] = 63;
                    2:       tb_vals[k] = 9 + int'($urandom_range(0, 1));
                    default: tb_vals[k] = int'($urandom_range(0, 63));
                endcase
            end
            run_batch(mask);
            repeat ($urandom_range(0, 12)) tick();
        end
        repeat (70) tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
